// File: rtl/ulpi_link_engine.sv
// ulpi_link_engine: ULPI link-layer engine in the PHY (CLKOUT) clock domain.
// Runs a timed PHY reset, then arbitrates the ULPI bus between PHY RX traffic,
// user register writes/reads and user PID transmits, and captures received
// packets into a small byte buffer.
// Optional feature macro: ULPI_AUTOCFG_EN -- when defined, OTG_CTRL <- 0x00 and
// FUNC_CTRL <- 0x45 are written automatically after the PHY reset.
module ulpi_link_engine #(
  parameter int RST_CYCLES = 100000,
  parameter int RX_DEPTH   = 16,
  parameter int RX_AW      = 4
) (
  input  logic             CLKOUT,
  input  logic             RESET,
  input  logic             ulpi_dir,
  input  logic             ulpi_nxt,
  output logic             ulpi_stp,
  input  logic [7:0]       ulpi_data_i,
  output logic [7:0]       ulpi_data_o,
  output logic             ulpi_data_oe,
  output logic             phy_rst,
  output logic             ready,
  input  logic             reg_req,
  input  logic             reg_we,
  input  logic [5:0]       reg_addr,
  input  logic [7:0]       reg_wdata,
  output logic             reg_ack,
  output logic [7:0]       reg_rdata,
  input  logic             tx_req,
  input  logic [3:0]       tx_pid,
  output logic             tx_ack,
  output logic [1:0]       linestate,
  output logic             rx_active,
  output logic             rx_pkt_valid,
  output logic [RX_AW:0]   rx_pkt_len,
  output logic             rx_pkt_ovf,
  input  logic [RX_AW-1:0] rx_rd_addr,
  output logic [7:0]       rx_rd_data
);
  localparam int RST_CW = $clog2(RST_CYCLES + 1);
`ifdef ULPI_AUTOCFG_EN
  localparam logic CFG_EN = 1'b1;
`else
  localparam logic CFG_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    ST_PHY_RST, ST_AUTOCFG, ST_IDLE, ST_RX, ST_TX_CMD, ST_TX_STP,
    ST_REGW_CMD, ST_REGW_DATA, ST_REGW_STP, ST_REGR_CMD, ST_REGR_TURN, ST_REGR_DATA
  } state_t;

  state_t            r_state, w_state_nxt, w_arb_state;
  logic [RST_CW-1:0] r_rst_cnt;
  logic [1:0]        r_cfg_step;
  logic              r_rd_done, r_dir_q;
  logic              r_stp, r_phy_rst, r_ready, r_reg_ack, r_tx_ack;
  logic [7:0]        r_data_o, r_reg_rdata, r_rd_data;
  logic [1:0]        r_linestate;
  logic              r_rx_active, r_open, r_ovf, r_pkt_valid, r_pkt_ovf;
  logic [RX_AW:0]    r_cnt, r_pkt_len;
  logic [7:0]        r_mem [RX_DEPTH];

  logic              w_cfg_active, w_rd_latch, w_rx_cyc, w_rxcmd, w_rxbyte, w_store;
  logic              w_rxact_cmd, w_dir_fall, w_open_evt, w_close_evt, w_open_nxt;
  logic [5:0]        w_wr_addr;
  logic [7:0]        w_wr_data, w_data_o_nxt;

  // Auto-config sequencing and write-path operand selection
  always_comb begin
    w_cfg_active = CFG_EN && (r_cfg_step != 2'd2);
    if (w_cfg_active) begin
      w_wr_addr = (r_cfg_step == 2'd0) ? 6'h0A : 6'h04;
      w_wr_data = (r_cfg_step == 2'd0) ? 8'h00 : 8'h45;
    end else begin
      w_wr_addr = reg_addr;
      w_wr_data = reg_wdata;
    end
  end

  // RX path decode: RXCMD vs packet byte, packet open/close events
  always_comb begin
    w_rd_latch  = (r_state == ST_REGR_DATA) && !r_rd_done && ulpi_dir;
    // dir must have been high last cycle too: the rising-dir cycle is a turnaround
    w_rx_cyc    = (r_state != ST_PHY_RST) && ulpi_dir && r_dir_q && !w_rd_latch;
    w_rxcmd     = w_rx_cyc && !ulpi_nxt;
    w_rxbyte    = w_rx_cyc && ulpi_nxt && r_open;
    w_store     = w_rxbyte && (r_cnt < (RX_AW+1)'(RX_DEPTH));
    w_rxact_cmd = (ulpi_data_i[5:4] == 2'b01);
    w_dir_fall  = (r_state != ST_PHY_RST) && !ulpi_dir && r_dir_q;
    w_open_evt  = w_rxcmd && w_rxact_cmd && !r_rx_active;
    w_close_evt = r_open && ((w_rxcmd && !w_rxact_cmd) || w_dir_fall);
    if (w_open_evt) begin
      w_open_nxt = 1'b1;
    end else if (w_close_evt) begin
      w_open_nxt = 1'b0;
    end else begin
      w_open_nxt = r_open;
    end
  end

  // Bus request arbitration: pending auto-config, then tx, then register access
  always_comb begin
    if (w_cfg_active) begin
      w_arb_state = ST_AUTOCFG;
    end else if (tx_req) begin
      w_arb_state = ST_TX_CMD;
    end else if (reg_req) begin
      w_arb_state = reg_we ? ST_REGW_CMD : ST_REGR_CMD;
    end else begin
      w_arb_state = ST_IDLE;
    end
  end

  // Next-state logic; dir rising in a command/data state aborts to the RX path
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_PHY_RST:   w_state_nxt = (r_rst_cnt == RST_CW'(RST_CYCLES - 1)) ?
                                  (CFG_EN ? ST_AUTOCFG : ST_IDLE) : ST_PHY_RST;
      ST_AUTOCFG:   w_state_nxt = ulpi_dir ? ST_RX : (w_cfg_active ? ST_REGW_CMD : ST_IDLE);
      ST_IDLE:      w_state_nxt = ulpi_dir ? ST_RX : w_arb_state;
      ST_RX:        w_state_nxt = ulpi_dir ? ST_RX : w_arb_state;
      ST_TX_CMD:    w_state_nxt = ulpi_dir ? ST_RX : (ulpi_nxt ? ST_TX_STP : ST_TX_CMD);
      ST_TX_STP:    w_state_nxt = ST_IDLE;
      ST_REGW_CMD:  w_state_nxt = ulpi_dir ? ST_RX : (ulpi_nxt ? ST_REGW_DATA : ST_REGW_CMD);
      ST_REGW_DATA: w_state_nxt = ulpi_dir ? ST_RX : (ulpi_nxt ? ST_REGW_STP : ST_REGW_DATA);
      ST_REGW_STP:  w_state_nxt = w_cfg_active ? ST_AUTOCFG : ST_IDLE;
      ST_REGR_CMD:  w_state_nxt = ulpi_dir ? ST_RX : (ulpi_nxt ? ST_REGR_TURN : ST_REGR_CMD);
      ST_REGR_TURN: w_state_nxt = ulpi_dir ? ST_REGR_DATA : ST_REGR_TURN;
      ST_REGR_DATA: w_state_nxt = ulpi_dir ? ST_REGR_DATA : ST_IDLE;
      default:      w_state_nxt = ST_PHY_RST;
    endcase
  end

  // Bus byte to drive in the upcoming state
  always_comb begin
    w_data_o_nxt = 8'h00;
    case (w_state_nxt)
      ST_TX_CMD:    w_data_o_nxt = {4'h4, tx_pid};
      ST_REGW_CMD:  w_data_o_nxt = {2'b10, w_wr_addr};
      ST_REGW_DATA: w_data_o_nxt = w_wr_data;
      ST_REGR_CMD:  w_data_o_nxt = {2'b11, reg_addr};
      default:      w_data_o_nxt = 8'h00;
    endcase
  end

  // FSM state, PHY reset timer, auto-config step and read-latch bookkeeping
  always_ff @(posedge CLKOUT) begin
    if (!RESET) begin
      r_state    <= ST_PHY_RST;
      r_rst_cnt  <= {RST_CW{1'b0}};
      r_cfg_step <= 2'd0;
      r_rd_done  <= 1'b0;
      r_dir_q    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dir_q   <= ulpi_dir;
      r_rd_done <= (r_state == ST_REGR_DATA) ? (r_rd_done | w_rd_latch) : 1'b0;
      if (r_state == ST_PHY_RST) begin
        r_rst_cnt <= r_rst_cnt + RST_CW'(1);
      end
      if ((r_state == ST_REGW_STP) && w_cfg_active) begin
        r_cfg_step <= r_cfg_step + 2'd1;
      end
    end
  end

  // Registered bus and handshake outputs, decoded from the upcoming state
  always_ff @(posedge CLKOUT) begin
    if (!RESET) begin
      r_data_o    <= 8'h00;
      r_stp       <= 1'b0;
      r_phy_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_tx_ack    <= 1'b0;
      r_reg_ack   <= 1'b0;
      r_reg_rdata <= 8'h00;
    end else begin
      r_data_o  <= w_data_o_nxt;
      r_stp     <= (w_state_nxt == ST_TX_STP) || (w_state_nxt == ST_REGW_STP);
      r_phy_rst <= (w_state_nxt == ST_PHY_RST);
      r_ready   <= (w_state_nxt == ST_IDLE) && !w_open_nxt;
      r_tx_ack  <= (w_state_nxt == ST_TX_STP);
      r_reg_ack <= ((w_state_nxt == ST_REGW_STP) && !w_cfg_active) || w_rd_latch;
      if (w_rd_latch) begin
        r_reg_rdata <= ulpi_data_i;
      end
    end
  end

  // RXCMD tracking, packet byte count, overflow and end-of-packet report
  always_ff @(posedge CLKOUT) begin
    if (!RESET) begin
      r_linestate <= 2'b00;
      r_rx_active <= 1'b0;
      r_open      <= 1'b0;
      r_cnt       <= {(RX_AW+1){1'b0}};
      r_ovf       <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_pkt_len   <= {(RX_AW+1){1'b0}};
      r_pkt_ovf   <= 1'b0;
    end else begin
      r_open      <= w_open_nxt;
      r_pkt_valid <= w_close_evt;
      if (w_rxcmd) begin
        r_linestate <= ulpi_data_i[1:0];
        r_rx_active <= w_rxact_cmd;
      end else if (w_dir_fall) begin
        r_rx_active <= 1'b0;
      end
      if (w_open_evt) begin
        r_cnt <= {(RX_AW+1){1'b0}};
        r_ovf <= 1'b0;
      end else if (w_store) begin
        r_cnt <= r_cnt + (RX_AW+1)'(1);
      end else if (w_rxbyte) begin
        r_ovf <= 1'b1;
      end
      if (w_close_evt) begin
        r_pkt_len <= r_cnt;
        r_pkt_ovf <= r_ovf;
      end
    end
  end

  // Packet buffer: single write port, registered read port
  always_ff @(posedge CLKOUT) begin
    if (w_store) begin
      r_mem[r_cnt[RX_AW-1:0]] <= ulpi_data_i;
    end
    r_rd_data <= r_mem[rx_rd_addr];
  end

  assign ulpi_data_oe = ~ulpi_dir;
  assign ulpi_data_o  = r_data_o;
  assign ulpi_stp     = r_stp;
  assign phy_rst      = r_phy_rst;
  assign ready        = r_ready;
  assign reg_ack      = r_reg_ack;
  assign reg_rdata    = r_reg_rdata;
  assign tx_ack       = r_tx_ack;
  assign linestate    = r_linestate;
  assign rx_active    = r_rx_active;
  assign rx_pkt_valid = r_pkt_valid;
  assign rx_pkt_len   = r_pkt_len;
  assign rx_pkt_ovf   = r_pkt_ovf;
  assign rx_rd_data   = r_rd_data;

endmodule

// File: tb/tb_ulpi_link_engine.sv
// Directed bench for ulpi_link_engine with a shortened PHY reset time.
module tb_ulpi_link_engine;
  localparam int RST_N = 20;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          CLKOUT = 1'b0;
  logic          RESET;
  logic          ulpi_dir, ulpi_nxt, ulpi_stp, ulpi_data_oe;
  logic [7:0]    ulpi_data_i, ulpi_data_o;
  logic          phy_rst, ready;
  logic          reg_req, reg_we, reg_ack;
  logic [5:0]    reg_addr;
  logic [7:0]    reg_wdata, reg_rdata;
  logic          tx_req, tx_ack;
  logic [3:0]    tx_pid;
  logic [1:0]    linestate;
  logic          rx_active, rx_pkt_valid, rx_pkt_ovf;
  logic [AW:0]   rx_pkt_len;
  logic [AW-1:0] rx_rd_addr;
  logic [7:0]    rx_rd_data;

  int n_checks  = 0;
  int n_errors  = 0;
  int n_reg_ack = 0;
  int n_tx_ack  = 0;
  logic [7:0] exp_pkt [3];

  ulpi_link_engine #(.RST_CYCLES(RST_N), .RX_DEPTH(DEPTH), .RX_AW(AW)) dut (
    .CLKOUT(CLKOUT), .RESET(RESET),
    .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_stp(ulpi_stp),
    .ulpi_data_i(ulpi_data_i), .ulpi_data_o(ulpi_data_o), .ulpi_data_oe(ulpi_data_oe),
    .phy_rst(phy_rst), .ready(ready),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata),
    .tx_req(tx_req), .tx_pid(tx_pid), .tx_ack(tx_ack),
    .linestate(linestate), .rx_active(rx_active),
    .rx_pkt_valid(rx_pkt_valid), .rx_pkt_len(rx_pkt_len), .rx_pkt_ovf(rx_pkt_ovf),
    .rx_rd_addr(rx_rd_addr), .rx_rd_data(rx_rd_data)
  );

  always #5 CLKOUT = ~CLKOUT;

  // Count acknowledge pulses seen on the falling edge
  always @(negedge CLKOUT) begin
    n_reg_ack <= n_reg_ack + ((reg_ack === 1'b1) ? 1 : 0);
    n_tx_ack  <= n_tx_ack + ((tx_ack === 1'b1) ? 1 : 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLKOUT);
  endtask

  // Count cycles phy_rst stays high after RESET release, bounded
  task automatic wait_phy_reset(input string tag);
    int cyc = 0;
    while (phy_rst === 1'b1 && cyc < 200) begin
      @(posedge CLKOUT);
      #1;
      cyc++;
    end
    chk(tag, cyc, RST_N);
    tick();
  endtask

  // PHY side of a register write: wait for the command byte, accept cmd and data
  task automatic phy_accept_write(input string tag, input logic [7:0] cmd, input logic [7:0] dat);
    int k = 0;
    while (ulpi_data_o !== cmd && k < 10) begin
      tick();
      k++;
    end
    chk({tag, "_cmd"}, ulpi_data_o, cmd);
    ulpi_nxt = 1'b1;
    tick();
    chk({tag, "_data"}, ulpi_data_o, dat);
    tick();
    chk({tag, "_stp"}, ulpi_stp, 1'b1);
    chk({tag, "_stp_data"}, ulpi_data_o, 8'h00);
    ulpi_nxt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b0; ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_i = 8'h00;
    reg_req = 1'b0; reg_we = 1'b0; reg_addr = 6'h00; reg_wdata = 8'h00;
    tx_req = 1'b0; tx_pid = 4'h0; rx_rd_addr = {AW{1'b0}};
    exp_pkt[0] = 8'h2D; exp_pkt[1] = 8'h00; exp_pkt[2] = 8'h10;
    repeat (3) tick();

    // reset values
    chk("rst_phy_rst", phy_rst, 1'b1);
    chk("rst_ready", ready, 1'b0);
    chk("rst_stp", ulpi_stp, 1'b0);
    chk("rst_data_o", ulpi_data_o, 8'h00);
    chk("rst_len", rx_pkt_len, 5'd0);
    RESET = 1'b1;
    wait_phy_reset("phy_rst_cycles");

`ifdef ULPI_AUTOCFG_EN
    chk("cfg_ready_low", ready, 1'b0);
    phy_accept_write("cfg_otg", 8'h8A, 8'h00);
    phy_accept_write("cfg_func", 8'h84, 8'h45);
    for (int k = 0; k < 10 && ready !== 1'b1; k++) tick();
    chk("cfg_ready", ready, 1'b1);
    chk("cfg_no_ack", n_reg_ack, 0);
`else
    chk("ready_after_rst", ready, 1'b1);
`endif

    // register write 0x16 <- 0x5A, nxt after two cycles
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = 6'h16; reg_wdata = 8'h5A;
    tick(); chk("wr_cmd0", ulpi_data_o, 8'h96); chk("wr_oe", ulpi_data_oe, 1'b1);
    tick(); chk("wr_cmd1", ulpi_data_o, 8'h96);
    ulpi_nxt = 1'b1;
    tick(); chk("wr_data", ulpi_data_o, 8'h5A);
    tick(); chk("wr_stp", ulpi_stp, 1'b1); chk("wr_stp_data", ulpi_data_o, 8'h00);
    chk("wr_ack", reg_ack, 1'b1);
    reg_req = 1'b0; ulpi_nxt = 1'b0;
    tick(); chk("wr_ack_pulse", reg_ack, 1'b0); chk("wr_stp_end", ulpi_stp, 1'b0);
    tick(); chk("wr_ack_count", n_reg_ack, 1); chk("wr_ready", ready, 1'b1);

    // register read 0x00, PHY returns 0x24
    reg_req = 1'b1; reg_we = 1'b0; reg_addr = 6'h00;
    tick(); chk("rd_cmd", ulpi_data_o, 8'hC0);
    ulpi_nxt = 1'b1;
    tick(); chk("rd_turn_data", ulpi_data_o, 8'h00);
    ulpi_nxt = 1'b0; ulpi_dir = 1'b1;
    tick(); chk("rd_oe", ulpi_data_oe, 1'b0);
    ulpi_data_i = 8'h24;
    tick(); chk("rd_rdata", reg_rdata, 8'h24); chk("rd_ack", reg_ack, 1'b1);
    ulpi_dir = 1'b0; reg_req = 1'b0; ulpi_data_i = 8'h00;
    tick(); chk("rd_ack_pulse", reg_ack, 1'b0); chk("rd_ready", ready, 1'b1);
    tick(); chk("rd_ack_count", n_reg_ack, 2);

    // RX packet: RXCMD 0x01, 0x10, bytes 2D 00 10, RXCMD 0x00
    ulpi_dir = 1'b1; ulpi_data_i = 8'h00;
    tick(); chk("rx_oe", ulpi_data_oe, 1'b0);
    ulpi_data_i = 8'h01;
    tick(); chk("rx_ls_j", linestate, 2'b01); chk("rx_act0", rx_active, 1'b0);
    ulpi_data_i = 8'h10;
    tick(); chk("rx_act1", rx_active, 1'b1); chk("rx_ls_se0", linestate, 2'b00);
    chk("rx_not_ready", ready, 1'b0);
    ulpi_nxt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ulpi_data_i = exp_pkt[i];
      tick();
    end
    ulpi_nxt = 1'b0; ulpi_data_i = 8'h00;
    tick(); chk("rx_valid", rx_pkt_valid, 1'b1); chk("rx_len", rx_pkt_len, 5'd3);
    chk("rx_ovf", rx_pkt_ovf, 1'b0); chk("rx_act_end", rx_active, 1'b0);
    chk("rx_ls_end", linestate, 2'b00);
    ulpi_dir = 1'b0;
    tick(); chk("rx_valid_pulse", rx_pkt_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rx_rd_addr = AW'(i);
      tick();
      chk("rx_buf", rx_rd_data, exp_pkt[i]);
    end

    // 20-byte packet closed by dir falling: saturates at DEPTH with overflow
    ulpi_dir = 1'b1; ulpi_data_i = 8'h00;
    tick();
    ulpi_data_i = 8'h10;
    tick();
    ulpi_nxt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ulpi_data_i = 8'hA0 + 8'(i);
      tick();
    end
    ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_i = 8'h00;
    tick(); chk("ovf_valid", rx_pkt_valid, 1'b1); chk("ovf_len", rx_pkt_len, 5'd16);
    chk("ovf_flag", rx_pkt_ovf, 1'b1); chk("ovf_ready", ready, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      rx_rd_addr = AW'(i);
      tick();
      chk("ovf_buf", rx_rd_data, 8'hA0 + 8'(i));
    end

    // tx PID 0x2 aborted by dir before nxt, then retried
    tx_req = 1'b1; tx_pid = 4'h2;
    tick(); chk("tx_cmd0", ulpi_data_o, 8'h42);
    ulpi_dir = 1'b1;
    tick(); chk("tx_abort_oe", ulpi_data_oe, 1'b0);
    tick();
    ulpi_dir = 1'b0;
    tick(); chk("tx_retry", ulpi_data_o, 8'h42); chk("tx_retry_oe", ulpi_data_oe, 1'b1);
    chk("tx_no_ack", n_tx_ack, 0);
    ulpi_nxt = 1'b1;
    tick(); chk("tx_stp", ulpi_stp, 1'b1); chk("tx_stp_data", ulpi_data_o, 8'h00);
    chk("tx_ack", tx_ack, 1'b1);
    tx_req = 1'b0; ulpi_nxt = 1'b0;
    tick(); chk("tx_ack_pulse", tx_ack, 1'b0);
    tick(); chk("tx_ack_count", n_tx_ack, 1);

    // simultaneous tx and reg requests: tx first, reg next
    tx_req = 1'b1; tx_pid = 4'hD;
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = 6'h04; reg_wdata = 8'h11;
    tick(); chk("sim_tx_first", ulpi_data_o, 8'h4D);
    ulpi_nxt = 1'b1;
    tick(); chk("sim_tx_ack", tx_ack, 1'b1); chk("sim_no_reg_ack", reg_ack, 1'b0);
    tx_req = 1'b0; ulpi_nxt = 1'b0;
    tick(); chk("sim_idle", ulpi_data_o, 8'h00);
    phy_accept_write("sim_reg", 8'h84, 8'h11);
    chk("sim_reg_ack", reg_ack, 1'b1);
    reg_req = 1'b0;
    tick(); tick(); chk("sim_reg_count", n_reg_ack, 3);

    // reset in the middle of a register write: aborted, no ack
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = 6'h3F; reg_wdata = 8'hFF;
    tick(); chk("mid_cmd", ulpi_data_o, 8'hBF);
    RESET = 1'b0; ulpi_nxt = 1'b1;
    tick(); chk("mid_data_o", ulpi_data_o, 8'h00); chk("mid_phy_rst", phy_rst, 1'b1);
    chk("mid_ready", ready, 1'b0); chk("mid_len", rx_pkt_len, 5'd0);
    chk("mid_ovf", rx_pkt_ovf, 1'b0);
    tick(); chk("mid_no_ack", reg_ack, 1'b0);
    reg_req = 1'b0; ulpi_nxt = 1'b0; RESET = 1'b1;
    wait_phy_reset("phy_rst_cycles2");
    chk("mid_ack_count", n_reg_ack, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
